// File: rtl/pipe_skid_reg_pkg.sv
// Shared state encoding and default sizing for the pipe_skid_reg skid buffer.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_INIT  = 0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload slot of the skid buffer: load-enabled register with synchronous INIT reset.
module pipe_skid_slot
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(DEF_INIT)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            data_q <= INIT;
        else if (ld_i)
            data_q <= d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Registered-ready skid buffer: main slot drives O, skid slot absorbs one beat of backpressure.
// Optional clock enable port CE is added when PIPE_SKID_REG_CE_EN is defined.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(DEF_INIT)
) (
    input  logic             CLK,
    input  logic             RESETN,
`ifdef PIPE_SKID_REG_CE_EN
    input  logic             CE,
`endif
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    input  logic             O_READY
);

    logic             ce;
    state_e           state_q, state_d;
    logic             main_ld, skid_ld, main_from_skid;
    logic [WIDTH-1:0] main_q, skid_q, main_d;
    logic             in_xfer, out_xfer;

`ifdef PIPE_SKID_REG_CE_EN
    assign ce = CE;
`else
    assign ce = 1'b1;
`endif

    // Handshakes decode from registered state only; O_READY never reaches I_READY.
    assign I_READY  = RESETN && ce && (state_q != SKID);
    assign O_VALID  = ce && (state_q != EMPTY);
    assign O        = main_q;
    assign in_xfer  = I_VALID && I_READY;
    assign out_xfer = O_VALID && O_READY;

    always_ff @(posedge CLK) begin
        if (!RESETN)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_ld = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (in_xfer && out_xfer) begin
                    main_ld = 1'b1;
                end else if (in_xfer) begin
                    skid_ld = 1'b1;
                    state_d = SKID;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (out_xfer) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : I;

    pipe_skid_slot #(.WIDTH(WIDTH), .INIT(INIT)) u_main (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .ld_i   (main_ld),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_skid_slot #(.WIDTH(WIDTH), .INIT(INIT)) u_skid (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .ld_i   (skid_ld),
        .d_i    (I),
        .q_o    (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg with an ordering scoreboard on the handshakes.
module tb_pipe_skid_reg;

    localparam int WIDTH = 2;

    logic             CLK = 1'b0;
    logic             RESETN;
    logic             CE;
    logic [WIDTH-1:0] I;
    logic             I_VALID;
    logic             I_READY;
    logic [WIDTH-1:0] O;
    logic             O_VALID;
    logic             O_READY;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] sb[$];

    pipe_skid_reg #(.WIDTH(WIDTH), .INIT(2'b00)) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
`ifdef PIPE_SKID_REG_CE_EN
        .CE      (CE),
`endif
        .I       (I),
        .I_VALID (I_VALID),
        .I_READY (I_READY),
        .O       (O),
        .O_VALID (O_VALID),
        .O_READY (O_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Handshakes are stable mid-cycle; record what will transfer at the next edge.
    always @(negedge CLK) begin
        if (RESETN === 1'b1) begin
            if (O_VALID === 1'b1 && O_READY === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", {30'd0, O}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_order", {30'd0, O}, {30'd0, sb.pop_front()});
                end
            end
            if (I_VALID === 1'b1 && I_READY === 1'b1)
                sb.push_back(I);
        end
    end

    initial begin
        RESETN = 1'b0; CE = 1'b1; I = 2'b11; I_VALID = 1'b1; O_READY = 1'b0;
        #1;
        check("rst_iready_comb", I_READY, 0);
        tick();
        check("rst1_iready", I_READY, 0);
        check("rst1_ovalid", O_VALID, 0);
        check("rst1_o", O, 0);
        tick();
        check("rst2_iready", I_READY, 0);
        check("rst2_ovalid", O_VALID, 0);
        check("rst2_o", O, 0);
        RESETN = 1'b1; I_VALID = 1'b0;
        #1;
        check("post_rst_iready", I_READY, 1);
        check("post_rst_ovalid", O_VALID, 0);
        check("post_rst_o", O, 0);
        sb.delete();

        // streaming at full rate
        O_READY = 1'b1;
        for (int v = 0; v < 4; v++) begin
            I = v[WIDTH-1:0]; I_VALID = 1'b1;
            tick();
            check("stream_o", O, v);
            check("stream_ovalid", O_VALID, 1);
            check("stream_iready", I_READY, 1);
        end
        I_VALID = 1'b0;
        tick();
        check("stream_drain", O_VALID, 0);

        // backpressure into skid
        O_READY = 1'b0; I = 2'd1; I_VALID = 1'b1;
        tick();
        check("bp_full_o", O, 1);
        I = 2'd2;
        tick();
        check("bp_skid_iready", I_READY, 0);
        check("bp_skid_o", O, 1);
        I_VALID = 1'b0;
        tick();
        check("bp_hold_o", O, 1);
        check("bp_hold_ovalid", O_VALID, 1);
        O_READY = 1'b1;
        tick();
        check("bp_pop_o", O, 2);
        check("bp_pop_iready", I_READY, 1);
        tick();
        check("bp_empty", O_VALID, 0);

        // simultaneous in/out while FULL
        O_READY = 1'b0; I = 2'd1; I_VALID = 1'b1;
        tick();
        O_READY = 1'b1; I = 2'd2;
        tick();
        check("sim_o", O, 2);
        check("sim_ovalid", O_VALID, 1);
        check("sim_iready", I_READY, 1);
        I_VALID = 1'b0;
        tick();
        check("sim_no_skid", O_VALID, 0);

        // reset while SKID discards both entries
        O_READY = 1'b0; I = 2'd1; I_VALID = 1'b1;
        tick();
        I = 2'd2;
        tick();
        check("mid_skid_iready", I_READY, 0);
        I_VALID = 1'b0; RESETN = 1'b0;
        #1;
        check("mid_rst_iready", I_READY, 0);
        tick();
        check("mid_rst_ovalid", O_VALID, 0);
        check("mid_rst_o", O, 0);
        sb.delete();
        RESETN = 1'b1; O_READY = 1'b1; I = 2'd3; I_VALID = 1'b1;
        tick();
        check("mid_after_o", O, 3);
        check("mid_after_ovalid", O_VALID, 1);
        I_VALID = 1'b0;
        tick();
        check("mid_after_empty", O_VALID, 0);

`ifdef PIPE_SKID_REG_CE_EN
        O_READY = 1'b0; I = 2'd1; I_VALID = 1'b1;
        tick();
        CE = 1'b0; I = 2'd2; O_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ce_ovalid", O_VALID, 0);
            check("ce_iready", I_READY, 0);
            check("ce_o", O, 1);
        end
        CE = 1'b1; I_VALID = 1'b0; O_READY = 1'b0;
        #1;
        check("ce_resume_o", O, 1);
        check("ce_resume_ovalid", O_VALID, 1);
        O_READY = 1'b1;
        tick();
        check("ce_drain", O_VALID, 0);
`endif

        tick();
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 2, giving the payload width in bits.
REQ-002 SHALL have parameter INIT, default 0, giving the reset value of both data slots.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESETN  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port I  input  WIDTH  upstream payload.
REQ-006 SHALL have port I_VALID  input  1  upstream payload valid.
REQ-007 SHALL have port I_READY  output  1  block can accept a payload this cycle.
REQ-008 SHALL have port O  output  WIDTH  payload to the downstream register stage.
REQ-009 SHALL have port O_VALID  output  1  O holds a valid payload.
REQ-010 SHALL have port O_READY  input  1  downstream accepts O this cycle.

Function
REQ-011 SHALL accept an input transfer on a cycle only when I_VALID=1 and I_READY=1, and deliver an output transfer only when O_VALID=1 and O_READY=1.
REQ-012 SHALL have three states: EMPTY (no entry), FULL (main slot valid), SKID (main and skid slots valid).
REQ-013 SHALL drive O from the main slot, O_VALID=1 in FULL and SKID, and O_VALID=0 in EMPTY.
REQ-014 SHALL drive I_READY=1 in EMPTY and FULL and I_READY=0 in SKID, decoded from registered state only, with no combinational path from O_READY.
REQ-015 EMPTY: on an input transfer, main<=I and go to FULL; otherwise stay.
REQ-016 FULL: on an input transfer plus an output transfer, main<=I and stay FULL.
REQ-017 FULL: on an input transfer without an output transfer, skid<=I and go to SKID.
REQ-018 FULL: on an output transfer without an input transfer, go to EMPTY; with neither, hold.
REQ-019 SKID: on an output transfer, main<=skid and go to FULL; otherwise hold.
REQ-020 SHALL give one-cycle latency from input transfer to O_VALID when EMPTY, and sustain one transfer per cycle while O_READY=1.
REQ-021 SHALL preserve order, and SHALL never drop or duplicate a payload.
REQ-022 SHALL leave O stable while O_VALID=1 and O_READY=0.

Reset
REQ-023 SHALL, when RESETN=0 at a rising edge, set the state to EMPTY and set the main and skid slots to INIT, taking priority over all other inputs.
REQ-024 SHALL force I_READY=0 while RESETN=0, so that no input transfer occurs during reset.
REQ-025 SHALL, on a reset in FULL or SKID, discard every held entry, with O_VALID=0 on the following cycle.
REQ-026 SHALL, after reset, present O=INIT, O_VALID=0 and I_READY=1 on the first cycle with RESETN=1.

Configuration
REQ-027 SHALL, with macro PIPE_SKID_REG_CE_EN defined, add port CE  input  1  clock enable.
REQ-028 SHALL, with PIPE_SKID_REG_CE_EN defined and CE=0, hold all state and data, and force I_READY=0 and O_VALID=0; reset still takes priority over CE.
REQ-029 SHALL, without PIPE_SKID_REG_CE_EN, omit the CE port and behave as if CE=1.

Structure
REQ-030 SHALL take the state enumeration (EMPTY, FULL, SKID) and default WIDTH/INIT constants from shared package pipe_skid_reg_pkg.
REQ-031 SHALL implement each data slot as sub-module pipe_skid_slot (WIDTH-bit load-enabled register with synchronous INIT reset), instantiated twice (main, skid).

Verification
REQ-032 SHALL cover reset: RESETN=0 for 2 cycles with I_VALID=1, I=2'b11 -> I_READY=0, O_VALID=0, O=2'b00; first cycle after release I_READY=1, O_VALID=0.
REQ-033 SHALL cover streaming: O_READY=1, push 0,1,2,3 on consecutive cycles -> O=0,1,2,3 one cycle later each, O_VALID continuously 1, I_READY continuously 1.
REQ-034 SHALL cover backpressure: O_READY=0, push 1 then 2 -> state SKID, I_READY=0, O=1 held; raise O_READY -> O=1 then O=2 on next cycle, I_READY=1 one cycle after the first output transfer.
REQ-035 SHALL cover a simultaneous in/out transfer in FULL: main=1, push 2 with O_READY=1 -> O=2 next cycle, state FULL, no skid use.
REQ-036 SHALL cover reset mid-operation: in SKID (main=1, skid=2) assert RESETN=0 for 1 cycle -> next cycle O_VALID=0, O=INIT; after release, push 3 -> O=3, with 1 and 2 never appearing.
REQ-037 SHALL cover clock enable with PIPE_SKID_REG_CE_EN: FULL with O=1, CE=0 for 3 cycles with I_VALID=1, O_READY=1 -> O_VALID=0, I_READY=0, main still 1; CE=1 -> O=1, O_VALID=1.
